// File: rtl/rv32_pkg.sv
// Shared RV32 constants for the front end and its benches.
package rv32_pkg;

    localparam int          XLEN             = 32;
    localparam int          INSTR_BYTES      = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;  // addi x0, x0, 0

endpackage

// File: rtl/fetch_unit.sv
// RV32 instruction fetch: owns the PC, drives the synchronous-read ROM and
// presents each returned word with its PC to decode over valid/ready.
module fetch_unit #(
    parameter int              XLEN     = rv32_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(rv32_pkg::RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            fetch_en,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] rom_addr,
    input  logic [XLEN-1:0] rom_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc
);

    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(rv32_pkg::INSTR_BYTES);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(rv32_pkg::INSTR_BYTES - 1);

    logic [XLEN-1:0] r_next_pc;
    logic [XLEN-1:0] r_resp_pc;
    logic            r_resp_vld;

    logic [XLEN-1:0] w_next_pc_d;
    logic [XLEN-1:0] w_resp_pc_d;
    logic            w_resp_vld_d;
    logic [XLEN-1:0] w_rom_addr;
    logic [XLEN-1:0] w_tgt;
    logic            w_stall;

    assign w_stall = r_resp_vld & ~instr_ready;
    assign w_tgt   = redirect_pc & ALIGN_MASK;

    // Redirect beats stall beats normal sequential fetch.
    always_comb begin
        // NOTE: every output gets a default before any branch, so no path can infer a latch.
        w_rom_addr   = r_next_pc;
        w_next_pc_d  = r_next_pc;
        w_resp_pc_d  = r_resp_pc;
        w_resp_vld_d = r_resp_vld;
        if (redirect_valid) begin
            w_rom_addr   = w_tgt;
            w_resp_pc_d  = w_tgt;
            w_resp_vld_d = fetch_en;
            w_next_pc_d  = fetch_en ? w_tgt + PC_STEP : w_tgt;
        end else if (w_stall) begin
            // Re-read the held word so rom_rdata stays stable while decode waits.
            w_rom_addr = r_resp_pc;
        end else if (fetch_en) begin
            w_resp_vld_d = 1'b1;
            w_resp_pc_d  = r_next_pc;
            w_next_pc_d  = r_next_pc + PC_STEP;
        end else begin
            w_resp_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so all registers update together at the edge.
        if (!rst_n) begin
            r_next_pc  <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_resp_vld <= 1'b0;
        end else begin
            r_next_pc  <= w_next_pc_d;
            r_resp_pc  <= w_resp_pc_d;
            r_resp_vld <= w_resp_vld_d;
        end
    end

    assign rom_addr    = w_rom_addr;
    assign instr_valid = r_resp_vld & rst_n;
    assign instr_pc    = r_resp_pc;
    assign instr       = rom_rdata;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a 64-word synchronous ROM model and a
// scoreboard of expected PCs pushed at issue and popped on acceptance.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] rom_addr;
    logic [31:0] rom_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    int checks   = 0;
    int failures = 0;

    logic [31:0] rom [64];
    logic [31:0] sb [$];

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .rom_addr       (rom_addr),
        .rom_rdata      (rom_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
    );

    always @(posedge clk) rom_rdata <= rom[rom_addr[7:2]];

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        if (a[7:2] == 6'd0)      return rv32_pkg::NOP_INSTR;
        else if (a[7:2] == 6'd1) return 32'h0050_0093;
        else                     return 32'hC0DE_0000 | {24'd0, a[7:2], 2'b00};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rn, input logic en, input logic rv,
                         input logic [31:0] rpc, input logic rdy);
        rst_n          = rn;
        fetch_en       = en;
        redirect_valid = rv;
        redirect_pc    = rpc;
        instr_ready    = rdy;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Sample mid-cycle; an accepted word retires the scoreboard head.
    task automatic sample(input string tag, input bit exp_vld, input logic [31:0] exp_addr);
        logic [31:0] e;
        @(negedge clk);
        chk({tag, " valid"}, {31'd0, instr_valid}, {31'd0, exp_vld});
        chk({tag, " rom_addr"}, rom_addr, exp_addr);
        if (exp_vld) begin
            checks++;
            assert (sb.size() != 0) else begin
                failures++;
                $error("FAIL %s scoreboard: observed=empty expected=entry", tag);
            end
            if (sb.size() != 0) begin
                e = sb[0];
                chk({tag, " instr_pc"}, instr_pc, e);
                chk({tag, " instr"}, instr, rom_word(e));
                if (instr_ready) void'(sb.pop_front());
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = rom_word(32'(i * 4));
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);

        // Reset state
        cyc();                                   sample("rst0", 0, 32'h0);
        cyc(); drive(1, 1, 0, 0, 1); sb.push_back(32'h0);  sample("first_issue", 0, 32'h0);

        // Sequential fetch
        cyc(); sb.push_back(32'h4);              sample("c1", 1, 32'h4);
        cyc(); sb.push_back(32'h8);              sample("c2", 1, 32'h8);

        // Three-cycle stall on 0x8
        cyc(); drive(1, 1, 0, 0, 0);             sample("stall1", 1, 32'h8);
        cyc();                                   sample("stall2", 1, 32'h8);
        cyc();                                   sample("stall3", 1, 32'h8);
        cyc(); drive(1, 1, 0, 0, 1); sb.push_back(32'hC);  sample("stall_rel", 1, 32'hC);
        cyc(); sb.push_back(32'h10);             sample("c7", 1, 32'h10);

        // Redirect to 0x40 with ready high, back to 0x10, then with ready low
        cyc(); drive(1, 1, 1, 32'h40, 1); sb.push_back(32'h40); sample("redir_rdy", 1, 32'h40);
        cyc(); drive(1, 1, 1, 32'h10, 1); sb.push_back(32'h10); sample("redir_back", 1, 32'h10);
        cyc(); drive(1, 1, 1, 32'h40, 0); sb.push_back(32'h40); sample("redir_stall", 1, 32'h40);
        void'(sb.pop_front());  // 0x10 is killed by the redirect
        cyc(); drive(1, 1, 0, 0, 1); sb.push_back(32'h44);      sample("after_kill", 1, 32'h44);

        // Misaligned target and PC wrap
        cyc(); drive(1, 1, 1, 32'h43, 1); sb.push_back(32'h40); sample("misalign", 1, 32'h40);
        cyc(); drive(1, 1, 1, 32'hFFFF_FFFC, 1); sb.push_back(32'hFFFF_FFFC); sample("to_top", 1, 32'hFFFF_FFFC);
        cyc(); drive(1, 1, 0, 0, 1); sb.push_back(32'h0);       sample("wrap", 1, 32'h0);

        // fetch_en drop while a word is stalled at 0x20
        cyc(); drive(1, 1, 1, 32'h20, 1); sb.push_back(32'h20); sample("to_20", 1, 32'h20);
        cyc(); drive(1, 0, 0, 0, 0);             sample("en0_hold1", 1, 32'h20);
        cyc();                                   sample("en0_hold2", 1, 32'h20);
        cyc(); drive(1, 0, 0, 0, 1);             sample("en0_accept", 1, 32'h24);
        cyc();                                   sample("en0_idle", 0, 32'h24);
        cyc(); drive(1, 1, 0, 0, 1); sb.push_back(32'h24); sample("en1_issue", 0, 32'h24);

        // Reset during a stall at 0x30
        cyc(); drive(1, 1, 1, 32'h30, 1); sb.push_back(32'h30); sample("to_30", 1, 32'h30);
        cyc(); drive(0, 1, 0, 0, 0);             sample("rst_mid", 0, 32'h30);
        sb.delete();
        cyc(); drive(1, 1, 0, 0, 1); sb.push_back(32'h0);  sample("post_rst", 0, 32'h0);
        cyc(); sb.push_back(32'h4);              sample("restart0", 1, 32'h4);
        cyc(); sb.push_back(32'h8);              sample("restart1", 1, 32'h8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage of the RV32 core, directly upstream of the synchronous-read instruction ROM and feeding decode.
- Owns the program counter and drives the byte address into the ROM.
- Tracks the ROM's one-cycle read latency and presents each returned word with its PC over a valid/ready handshake.
- Handles decode back-pressure, redirects from execute (branch/jump), and a global fetch enable.

Parameters:
XLEN, 32, data/address width
RESET_PC, 32'h0000_0000, first byte address fetched after reset; bits [1:0] must be 0

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
fetch_en  in  1  1 = issue new fetches
redirect_valid  in  1  redirect request this cycle
redirect_pc  in  XLEN  redirect target, byte address
rom_addr  out  XLEN  byte address to the ROM; combinational from internal state and inputs
rom_rdata  in  XLEN  ROM read data; word at the rom_addr sampled on the previous edge
instr_valid  out  1  instr/instr_pc valid
instr_ready  in  1  decode accepts this cycle
instr  out  XLEN  instruction word; equals rom_rdata
instr_pc  out  XLEN  byte address of instr

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n, sampled on the rising edge of clk.
- State registers:
  - next_pc_q: next address to issue.
  - resp_pc_q: address whose data is on rom_rdata.
  - resp_vld_q: response valid.
- Outputs: instr_valid = resp_vld_q; instr_pc = resp_pc_q; instr = rom_rdata. No extra latency.
- Reset values: resp_vld_q=0, next_pc_q=RESET_PC, resp_pc_q=RESET_PC.
  - While rst_n=0, instr_valid=0.
  - Reset asserted mid-operation (including mid-stall) drops any in-flight word; instr_valid is 0 in the cycle after the reset edge.
- Latency: an address issued in cycle t appears as instr in cycle t+1. After reset release, first instr_valid=1 occurs one cycle after the first cycle with rst_n=1 and fetch_en=1.
- Per-cycle priority (accept = instr_valid & instr_ready; stall = instr_valid & ~instr_ready):
  1. redirect_valid=1:
     - tgt = {redirect_pc[31:2],2'b00}; misaligned low bits are silently cleared.
     - rom_addr=tgt; resp_pc_d=tgt.
     - If fetch_en: resp_vld_d=1, next_pc_d=tgt+4. Else: resp_vld_d=0, next_pc_d=tgt.
     - The current output is killed and never re-presented, whether or not instr_ready is high.
     - Redirect overrides a stall.
  2. stall:
     - rom_addr=resp_pc_q, so the ROM re-reads the same word and rom_rdata stays stable.
     - All registers hold.
  3. otherwise:
     - rom_addr=next_pc_q.
     - If fetch_en: resp_vld_d=1, resp_pc_d=next_pc_q, next_pc_d=next_pc_q+4.
     - Else: resp_vld_d=0, other registers hold.
- fetch_en low never drops an un-accepted valid word; that word waits for instr_ready. Fetch resumes at next_pc_q with no skip or duplicate.
- PC arithmetic: modulo 2^XLEN; 0xFFFF_FFFC+4 = 0x0000_0000.
- Exactly-once: every issued, non-killed address is presented until accepted, in program order, never duplicated after acceptance.
- No combinational path from rom_rdata to any output other than instr.

Decomposition:
- Shared package rv32_pkg: XLEN, INSTR_BYTES=4, default RESET_PC, NOP encoding 32'h0000_0013 for benches.
- No sub-module: state is three registers plus a next-state mux; keep it a single module.

Test Plan:
1. Reset release; ROM[0]=32'h0000_0013, ROM[1]=32'h0050_0093; fetch_en=1, ready=1 -> cycle 1: valid=1, pc=0x0, instr=0x00000013. Cycle 2: pc=0x4, instr=0x00500093. Then pc +4 per cycle.
2. ready=0 for 3 cycles while pc=0x8 -> instr_pc=0x8, rom_addr=0x8, instr constant for 3 cycles. Cycle after ready=1 -> pc=0xC. 0x8 accepted exactly once.
3. redirect_valid with redirect_pc=0x40 while pc=0x10 valid (ready=1 and, separately, ready=0) -> next cycle pc=0x40, instr=ROM[16]. 0x10 not re-presented; 0x14 never presented.
4. redirect_pc=0x43 -> instr_pc=0x40. redirect_pc=0xFFFF_FFFC -> next presented pc=0x0000_0000.
5. fetch_en=0 at pc=0x20 with ready=0 -> 0x20 held until ready=1, then instr_valid=0. fetch_en=1 -> next pc=0x24.
6. rst_n=0 for 1 cycle during a stall at pc=0x30 -> instr_valid=0 the cycle after the reset edge. Fetch restarts at RESET_PC.
